wb_lsu_master: RTL and testbench

//  Wishbone initiator for the load/store stage: accepts one memory request at a time from the

---
 rtl/wb_pkg.sv | 61 ++++++
 rtl/wb_if.sv | 20 ++
 rtl/wb_load_extend.sv | 23 ++
 rtl/wb_lsu_master.sv | 155 +++++++++++++++
 tb/tb_wb_lsu_master.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Wishbone/LSU shared types: transfer width encoding, LSU FSM states, latched
// request payload and small helpers for width normalisation, alignment and
// store-lane masking. Shared by the master and the slave side.
package wb_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    WB_BYTE = 2'b00,
    WB_HALF = 2'b01,
    WB_WORD = 2'b10
  } wb_width_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    ERR  = 2'b10,
    RESP = 2'b11
  } lsu_state_t;

  // Request fields held for the whole transaction (address kept separately, it is parameterised)
  typedef struct packed {
    logic              we;
    logic              sgn;
    wb_width_t         width;
    logic [DATA_W-1:0] wdata;
  } lsu_req_t;

  // Encoding 2'b11 behaves as a word access
  function automatic wb_width_t norm_width(input logic [1:0] w);
    wb_width_t r;
    unique case (w)
      2'b00:   r = WB_BYTE;
      2'b01:   r = WB_HALF;
      default: r = WB_WORD;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input wb_width_t w, input logic [1:0] a);
    logic r;
    unique case (w)
      WB_BYTE: r = 1'b0;
      WB_HALF: r = a[0];
      default: r = (a != 2'b00);
    endcase
    return r;
  endfunction

  // Store data is lane-0 justified; unused upper lanes are driven as zero
  function automatic logic [DATA_W-1:0] mask_wdata(input wb_width_t w, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    unique case (w)
      WB_BYTE: r = {{(DATA_W-8){1'b0}}, d[7:0]};
      WB_HALF: r = {{(DATA_W-16){1'b0}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Classic single-cycle Wishbone bundle.
// master: cyc, stb, we, addr, width, data_write out; data_read, ack in.
// slave : mirror of master.
interface WISHBONE_IF #(
  parameter int unsigned ADDR_W = 32
);
  import wb_pkg::*;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] addr;
  wb_width_t         width;
  logic [DATA_W-1:0] data_write;
  logic [DATA_W-1:0] data_read;
  logic              ack;

  modport master (output cyc, stb, we, addr, width, data_write, input data_read, ack);
  modport slave  (input cyc, stb, we, addr, width, data_write, output data_read, ack);
endinterface

// File: rtl/wb_load_extend.sv
// Combinational load-data extension: picks the low byte/half/word of the
// read data and sign- or zero-extends it to 32 bits.
// Ports: width (transfer size), sgn (1 = sign-extend), data (raw read data),
//        ext_c (extended result).
module wb_load_extend
  import wb_pkg::*;
(
  input  wb_width_t         width,
  input  logic              sgn,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] ext_c
);

  always_comb begin
    ext_c = data;
    unique case (width)
      WB_BYTE: ext_c = {{(DATA_W-8){sgn & data[7]}}, data[7:0]};
      WB_HALF: ext_c = {{(DATA_W-16){sgn & data[15]}}, data[15:0]};
      default: ext_c = data;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Load/store Wishbone initiator. Takes one pipeline request at a time, checks
// alignment, runs one classic Wishbone cycle (aborted after TIMEOUT cycles
// without ack) and returns extended load data or store completion.
// Ports: iClk/iRst (sync active-high reset); req_* request handshake and
//        payload; rsp_* response handshake, data and error flags;
//        mem_wb Wishbone master port.
module wb_lsu_master
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_width,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_misalign,
  WISHBONE_IF.master        mem_wb
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_t        state_q, state_d;
  lsu_req_t          lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  logic              ready_d, vld_d, err_d, mis_d;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] ext_c;

  wb_load_extend u_ext (
    .width (lat_q.width),
    .sgn   (lat_q.sgn),
    .data  (mem_wb.data_read),
    .ext_c (ext_c)
  );

  // Bus outputs come straight from registers; address/control only change on accept
  assign mem_wb.cyc        = cyc_q;
  assign mem_wb.stb        = cyc_q;
  assign mem_wb.we         = lat_q.we;
  assign mem_wb.addr       = addr_q;
  assign mem_wb.width      = lat_q.width;
  assign mem_wb.data_write = lat_q.wdata;

  // State and registered outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      cyc_q        <= 1'b0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      rsp_misalign <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      req_ready    <= ready_d;
      rsp_valid    <= vld_d;
      rsp_data     <= data_d;
      rsp_err      <= err_d;
      rsp_misalign <= mis_d;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    ready_d = req_ready;
    vld_d   = rsp_valid;
    data_d  = rsp_data;
    err_d   = rsp_err;
    mis_d   = rsp_misalign;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          lat_d.we    = req_we;
          lat_d.sgn   = req_signed;
          lat_d.width = norm_width(req_width);
          lat_d.wdata = mask_wdata(norm_width(req_width), req_wdata);
          addr_d      = req_addr;
          cnt_d       = '0;
          ready_d     = 1'b0;
          if (is_misaligned(norm_width(req_width), req_addr[1:0])) begin
            state_d = ERR;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
          end
        end
      end
      BUS: begin
        // ack is checked first so an ack on the last counted cycle completes normally
        if (mem_wb.ack) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          vld_d   = 1'b1;
          err_d   = 1'b0;
          mis_d   = 1'b0;
          data_d  = lat_q.we ? '0 : ext_c;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          vld_d   = 1'b1;
          err_d   = 1'b1;
          mis_d   = 1'b0;
          data_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        state_d = RESP;
        vld_d   = 1'b1;
        err_d   = 1'b1;
        mis_d   = 1'b1;
        data_d  = '0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          ready_d = 1'b1;
          vld_d   = 1'b0;
          err_d   = 1'b0;
          mis_d   = 1'b0;
          data_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
module tb_wb_lsu_master;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_width = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_misalign;

  int checks = 0;
  int errors = 0;

  // Slave BFM controls and monitor state
  logic        ack_en = 1'b1;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          stb_cnt = 0;
  int          cyc_cnt = 0;
  logic        last_we = 1'b0;
  logic [1:0]  last_width = '0;
  logic [31:0] last_dw = '0;
  logic [7:0]  ram [256];

  WISHBONE_IF #(.ADDR_W(32)) bus ();

  wb_lsu_master #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .iClk         (clk),
    .iRst         (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_width    (req_width),
    .req_signed   (req_signed),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .rsp_misalign (rsp_misalign),
    .mem_wb       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {ram[a3], ram[a2], ram[a1], ram[a]};
  endfunction

  assign bus.ack       = bus.cyc & bus.stb & ack_en & (wait_cnt >= ack_delay);
  assign bus.data_read = rd_word(bus.addr[7:0]);

  always @(posedge clk) begin
    if (!bus.stb) wait_cnt <= 0;
    else if (!bus.ack) wait_cnt <= wait_cnt + 1;
    if (bus.stb) begin
      stb_cnt    <= stb_cnt + 1;
      last_we    <= bus.we;
      last_width <= bus.width;
      last_dw    <= bus.data_write;
    end
    if (bus.cyc) cyc_cnt <= cyc_cnt + 1;
    if (bus.cyc && bus.stb && bus.ack && bus.we) begin
      ram[bus.addr[7:0]] <= bus.data_write[7:0];
      if (bus.width != WB_BYTE) ram[bus.addr[7:0] + 8'd1] <= bus.data_write[15:8];
      if (bus.width == WB_WORD) begin
        ram[bus.addr[7:0] + 8'd2] <= bus.data_write[23:16];
        ram[bus.addr[7:0] + 8'd3] <= bus.data_write[31:24];
      end
    end
  end

  // Present one request for a single cycle starting at a negedge
  task automatic do_req(input logic we, input logic [31:0] a, input logic [1:0] w,
                        input logic s, input logic [31:0] d);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_width  = w;
    req_signed = s;
    req_wdata  = d;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic wait_rsp(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got ready=%b valid=%b err=%b mis=%b exp 1 0 0 0",
               req_ready, rsp_valid, rsp_err, rsp_misalign);
    end
    checks++;
    if (bus.cyc !== 1'b0 || bus.stb !== 1'b0 || bus.we !== 1'b0 || bus.addr !== 32'h0 ||
        bus.width !== WB_BYTE || bus.data_write !== 32'h0 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got cyc=%b stb=%b we=%b addr=%h w=%b dw=%h rd=%h exp all zero",
               bus.cyc, bus.stb, bus.we, bus.addr, bus.width, bus.data_write, rsp_data);
    end
  endtask

  task automatic test_store();
    int   s0;
    logic ok;
    ack_en = 1'b1;
    ack_delay = 0;
    s0 = stb_cnt;
    do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
    wait_rsp(ok);
    checks++;
    if (!ok || stb_cnt - s0 != 1) begin
      errors++;
      $display("FAIL store_word got ok=%b stb_cycles=%0d exp 1 1", ok, stb_cnt - s0);
    end
    checks++;
    if (last_we !== 1'b1 || last_width !== 2'b10 || last_dw !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_bus got we=%b w=%b dw=%h exp 1 10 deadbeef", last_we, last_width, last_dw);
    end
    checks++;
    if (rsp_err !== 1'b0 || rsp_data !== 32'h0 || rsp_misalign !== 1'b0) begin
      errors++;
      $display("FAIL store_rsp got err=%b data=%h mis=%b exp 0 0 0", rsp_err, rsp_data, rsp_misalign);
    end
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL store_done got valid=%b ready=%b exp 0 1", rsp_valid, req_ready);
    end
    // Byte store drives only lane 0
    do_req(1'b1, 32'h20, 2'b00, 1'b0, 32'hFFFFFF5A);
    wait_rsp(ok);
    checks++;
    if (!ok || last_dw !== 32'h0000005A || last_width !== 2'b00) begin
      errors++;
      $display("FAIL store_byte got ok=%b dw=%h w=%b exp 1 0000005a 00", ok, last_dw, last_width);
    end
    consume();
  endtask

  task automatic test_loads();
    logic [31:0] addr_v  [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h20};
    logic [1:0]  width_v [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
    logic        sgn_v   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exp_v   [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'hDEADBEEF, 32'h0000005A};
    logic ok;
    ack_delay = 1;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, addr_v[i], width_v[i], sgn_v[i], 32'h0);
      wait_rsp(ok);
      checks++;
      if (!ok || rsp_data !== exp_v[i] || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d got ok=%b data=%h err=%b exp 1 %h 0", i, ok, rsp_data, rsp_err, exp_v[i]);
      end
      consume();
    end
  endtask

  task automatic test_misalign();
    logic [31:0] addr_v  [2] = '{32'h11, 32'h12};
    logic [1:0]  width_v [2] = '{2'b01, 2'b10};
    int   c0;
    logic ok;
    for (int i = 0; i < 2; i++) begin
      c0 = cyc_cnt;
      do_req(1'b0, addr_v[i], width_v[i], 1'b0, 32'h0);
      wait_rsp(ok);
      checks++;
      if (!ok || cyc_cnt != c0 || rsp_err !== 1'b1 || rsp_misalign !== 1'b1 || rsp_data !== 32'h0) begin
        errors++;
        $display("FAIL misalign_%0d got ok=%b cyc_cycles=%0d err=%b mis=%b data=%h exp 1 0 1 1 0",
                 i, ok, cyc_cnt - c0, rsp_err, rsp_misalign, rsp_data);
      end
      consume();
    end
  endtask

  task automatic test_timeout();
    int   s0;
    logic ok;
    ack_en = 1'b0;
    s0 = stb_cnt;
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    wait_rsp(ok);
    checks++;
    if (!ok || stb_cnt - s0 != 16 || rsp_err !== 1'b1 || rsp_misalign !== 1'b0 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL timeout got ok=%b stb_cycles=%0d err=%b mis=%b data=%h exp 1 16 1 0 0",
               ok, stb_cnt - s0, rsp_err, rsp_misalign, rsp_data);
    end
    consume();
    // ack arriving in the 16th stb cycle completes normally
    ack_en = 1'b1;
    ack_delay = 15;
    s0 = stb_cnt;
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    wait_rsp(ok);
    checks++;
    if (!ok || stb_cnt - s0 != 16 || rsp_err !== 1'b0 || rsp_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL late_ack got ok=%b stb_cycles=%0d err=%b data=%h exp 1 16 0 deadbeef",
               ok, stb_cnt - s0, rsp_err, rsp_data);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int   s0;
    logic ok;
    ack_delay = 3;
    s0 = stb_cnt;
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    wait_rsp(ok);
    checks++;
    if (!ok || stb_cnt - s0 != 4) begin
      errors++;
      $display("FAIL bp_latency got ok=%b stb_cycles=%0d exp 1 4", ok, stb_cnt - s0);
    end
    // New request presented while the response is held must be ignored
    req_valid = 1'b1;
    req_addr  = 32'h20;
    req_width = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || req_ready !== 1'b0 || bus.cyc !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got valid=%b data=%h ready=%b cyc=%b exp 1 deadbeef 0 0",
                 i, rsp_valid, rsp_data, req_ready, bus.cyc);
      end
    end
    req_valid = 1'b0;
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got valid=%b ready=%b exp 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    ack_en = 1'b0;
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.cyc !== 1'b1 || bus.stb !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got cyc=%b stb=%b exp 1 1", bus.cyc, bus.stb);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cyc !== 1'b0 || bus.stb !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid got cyc=%b stb=%b valid=%b ready=%b exp 0 0 0 1",
               bus.cyc, bus.stb, rsp_valid, req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_after got valid=%b ready=%b exp 0 1", rsp_valid, req_ready);
    end
    ack_en = 1'b1;
    ack_delay = 0;
    do_req(1'b0, 32'h10, 2'b00, 1'b1, 32'h0);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_data !== 32'hFFFFFFEF || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_recover got ok=%b data=%h err=%b exp 1 ffffffef 0", ok, rsp_data, rsp_err);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_store();
    test_loads();
    test_misalign();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
